refund_dispenser: RTL
=====================

Name: refund_dispenser

Overview:
- Back end of the claw machine's refund path: accepts the one-cycle `balance` refund value from the claw controller and pays it out as individual $1 coins through a pulse-driven coin hopper.
- Accumulates outstanding refunds, drives the hopper solenoid, confirms each coin with the exit sensor, retries on timeout and latches a jam fault.
- Sits between the claw FSM outputs and the physical hopper driver.

Parameters:
- PULSE_CYCLES, 4: cycles `hopper_pulse` stays high per coin attempt (≥1).
- TIMEOUT_CYCLES, 1000: cycles to wait for `coin_det` after a pulse before declaring a miss (≥2).
- GAP_CYCLES, 2: dead cycles after a confirmed coin before the next pulse (≥1).
- MAX_RETRY, 2: misses allowed for one coin before JAM (≥0).

Ports:
- clk  in  1  system clock, rising edge.
- rstn  in  1  asynchronous active-low reset.
- enable  in  1  global advance enable; same semantics as the claw controller.
- balance  in  4  refund request, 0..14; a non-zero value is a one-cycle request for that many dollars.
- coin_det  in  1  hopper exit sensor, high while a coin passes; synchronous to clk.
- clr_jam  in  1  one-cycle jam acknowledge.
- hopper_pulse  out  1  hopper solenoid drive.
- busy  out  1  high whenever pending≠0 or FSM≠IDLE.
- pending  out  5  dollars still owed, saturating at 31.
- jam  out  1  high in JAM state.
- ovf  out  1  sticky; set when a pending add saturates.
- spurious  out  1  sticky; set when coin_det is high outside WAIT_DET.
- dispensed_count  out  32  total coins confirmed since reset; wraps at 2^32.
- pending_tens_LED  out  7  7-segment tens digit of pending (optional feature).
- pending_units_LED  out  7  7-segment units digit of pending (optional feature).

Behaviour:
- Reset (rstn low, async): FSM=IDLE; all counters and timers 0; hopper_pulse, busy, jam, ovf, spurious = 0; pending=0; dispensed_count=0.
- enable low: all state, counters and timers hold; balance, coin_det and clr_jam are ignored; hopper_pulse holds its registered value.
- Accumulate (enable high, balance≠0): pending <= pending + balance.
  - Result >31 → pending=31 and ovf<=1.
  - Same cycle as a coin confirm → pending <= sat(pending + balance − 1).
  - Accepted in every state, including JAM.
- FSM states: IDLE, PULSE, WAIT_DET, GAP, JAM. All outputs are registered, so hopper_pulse rises the cycle after the IDLE→PULSE decision.
  - IDLE: pending≠0 → PULSE, with the pulse timer loaded with PULSE_CYCLES.
  - PULSE: hopper_pulse=1. Timer reaches 1 → WAIT_DET with the wait timer = TIMEOUT_CYCLES. hopper_pulse is high for exactly PULSE_CYCLES enabled cycles.
  - WAIT_DET, coin_det=1 (first cycle high only): pending −1, dispensed_count +1, retry count cleared → GAP with GAP_CYCLES.
  - WAIT_DET, timeout expiry without coin_det:
    - retry<MAX_RETRY → retry+1 → PULSE.
    - Otherwise → JAM.
  - GAP: count down → IDLE. coin_det high here sets spurious and does not decrement.
  - JAM: jam=1, hopper_pulse=0. clr_jam → IDLE with retry cleared; pending is retained and dispensing resumes.
- coin_det high in IDLE, PULSE or GAP → spurious<=1; pending and count unchanged.
- A coin_det level held high for multiple cycles counts as one coin (edge on entry to WAIT_DET or rising edge within it).
- busy is combinational from registered state and pending.

Optional Feature:
- Macro: REFUND_LED_EN.
- Defined: pending_tens_LED / pending_units_LED show pending in decimal (0..31) using the team's active-high abcdefg segment encoding (0=1111110, 1=0110000, …, 9=1111011), registered with the other outputs; reset shows 00.
- Undefined: both LED ports are present and tied to 7'b0000000; no decoder logic is synthesised.

Test Plan:
- Reset, enable=1, balance=3 for one cycle, coin_det pulsed 2 cycles after each pulse ends → exactly 3 hopper pulses of 4 cycles each; pending 3→0; dispensed_count=3; busy drops after the final GAP.
- pending=2 mid-dispense; balance=14 on the same cycle as a coin confirm → pending=15; ovf=0.
- Request 14, then 14, then 5 before any coin → pending saturates at 31; ovf=1 and stays 1.
- balance=1, coin_det never asserted → 3 pulses spaced by TIMEOUT; jam=1, pending=1; clr_jam then coin_det → pending=0, jam=0, count=1.
- coin_det pulsed in IDLE with pending=0 → spurious=1; count and pending unchanged; no pulse.
- enable=0 during PULSE for 10 cycles → hopper_pulse and timers frozen; resumes and completes the remaining pulse cycles when enable=1. Separately, assert rstn low mid-WAIT_DET → all outputs immediately return to reset values.

Source files
------------

// File: rtl/refund_dispenser.sv
// Coin refund dispenser: accumulates refund dollars and pays them out one hopper pulse per coin.
// Latency: hopper_pulse rises 1 cycle after the IDLE->PULSE decision; all outputs registered.
// Backpressure: enable low freezes all state; REFUND_LED_EN adds 7-segment pending display.
module refund_dispenser #(
    parameter int PULSE_CYCLES   = 4,
    parameter int TIMEOUT_CYCLES = 1000,
    parameter int GAP_CYCLES     = 2,
    parameter int MAX_RETRY      = 2
) (
    input  logic        clk,
    input  logic        rstn,
    input  logic        enable,
    input  logic [3:0]  balance,
    input  logic        coin_det,
    input  logic        clr_jam,
    output logic        hopper_pulse,
    output logic        busy,
    output logic [4:0]  pending,
    output logic        jam,
    output logic        ovf,
    output logic        spurious,
    output logic [31:0] dispensed_count,
    output logic [6:0]  pending_tens_LED,
    output logic [6:0]  pending_units_LED
);
    typedef enum logic [2:0] {IDLE, PULSE, WAIT_DET, GAP, JAM} state_t;

    localparam logic [31:0] PULSE_LD   = 32'(PULSE_CYCLES);
    localparam logic [31:0] TIMEOUT_LD = 32'(TIMEOUT_CYCLES);
    localparam logic [31:0] GAP_LD     = 32'(GAP_CYCLES);
    localparam logic [7:0]  MAX_R      = 8'(MAX_RETRY);

    state_t      state_q, state_d;
    logic [31:0] timer_q, timer_d;
    logic [7:0]  retry_q, retry_d;
    logic [4:0]  pend_q, pend_d;
    logic [31:0] cnt_q, cnt_d;
    logic        ovf_q, ovf_d;
    logic        spur_q, spur_d;
    logic        pulse_q, jam_q;
    logic        confirm;
    logic [5:0]  sum;

    always_comb begin
        state_d = state_q;
        timer_d = timer_q;
        retry_d = retry_q;
        pend_d  = pend_q;
        cnt_d   = cnt_q;
        ovf_d   = ovf_q;
        spur_d  = spur_q;
        confirm = 1'b0;
        sum     = 6'd0;
        if (enable) begin
            case (state_q)
                IDLE: begin
                    if (pend_q != 5'd0) begin
                        state_d = PULSE;
                        timer_d = PULSE_LD;
                    end
                end
                PULSE: begin
                    if (timer_q <= 32'd1) begin
                        state_d = WAIT_DET;
                        timer_d = TIMEOUT_LD;
                    end else begin
                        timer_d = timer_q - 32'd1;
                    end
                end
                WAIT_DET: begin
                    // WAIT_DET is left on the first high sample, so any high here is a new coin
                    if (coin_det) begin
                        confirm = 1'b1;
                        cnt_d   = cnt_q + 32'd1;
                        retry_d = 8'd0;
                        state_d = GAP;
                        timer_d = GAP_LD;
                    end else if (timer_q <= 32'd1) begin
                        if (retry_q < MAX_R) begin
                            retry_d = retry_q + 8'd1;
                            state_d = PULSE;
                            timer_d = PULSE_LD;
                        end else begin
                            state_d = JAM;
                            timer_d = 32'd0;
                        end
                    end else begin
                        timer_d = timer_q - 32'd1;
                    end
                end
                GAP: begin
                    if (timer_q <= 32'd1) begin
                        state_d = IDLE;
                        timer_d = 32'd0;
                    end else begin
                        timer_d = timer_q - 32'd1;
                    end
                end
                JAM: begin
                    if (clr_jam) begin
                        state_d = IDLE;
                        retry_d = 8'd0;
                    end
                end
                default: state_d = IDLE;
            endcase

            if (coin_det && (state_q == IDLE || state_q == PULSE || state_q == GAP))
                spur_d = 1'b1;

            sum = {1'b0, pend_q} + {2'b00, balance} - {5'd0, confirm};
            if (sum > 6'd31) begin
                pend_d = 5'd31;
                ovf_d  = 1'b1;
            end else begin
                pend_d = sum[4:0];
            end
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q <= IDLE;
            timer_q <= 32'd0;
            retry_q <= 8'd0;
            pend_q  <= 5'd0;
            cnt_q   <= 32'd0;
            ovf_q   <= 1'b0;
            spur_q  <= 1'b0;
            pulse_q <= 1'b0;
            jam_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            timer_q <= timer_d;
            retry_q <= retry_d;
            pend_q  <= pend_d;
            cnt_q   <= cnt_d;
            ovf_q   <= ovf_d;
            spur_q  <= spur_d;
            pulse_q <= (state_d == PULSE);
            jam_q   <= (state_d == JAM);
        end
    end

    assign hopper_pulse    = pulse_q;
    assign jam             = jam_q;
    assign pending         = pend_q;
    assign ovf             = ovf_q;
    assign spurious        = spur_q;
    assign dispensed_count = cnt_q;
    assign busy            = (pend_q != 5'd0) || (state_q != IDLE);

`ifdef REFUND_LED_EN
    function automatic logic [6:0] seg7(input logic [3:0] d);
        case (d)
            4'd0:    seg7 = 7'b1111110;
            4'd1:    seg7 = 7'b0110000;
            4'd2:    seg7 = 7'b1101101;
            4'd3:    seg7 = 7'b1111001;
            4'd4:    seg7 = 7'b0110011;
            4'd5:    seg7 = 7'b1011011;
            4'd6:    seg7 = 7'b1011111;
            4'd7:    seg7 = 7'b1110000;
            4'd8:    seg7 = 7'b1111111;
            4'd9:    seg7 = 7'b1111011;
            default: seg7 = 7'b0000000;
        endcase
    endfunction

    logic [3:0] tens_v, units_v;
    logic [6:0] tens_q, units_q;

    always_comb begin
        tens_v  = 4'(pend_d / 5'd10);
        units_v = 4'(pend_d % 5'd10);
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            tens_q  <= 7'b1111110;
            units_q <= 7'b1111110;
        end else begin
            tens_q  <= seg7(tens_v);
            units_q <= seg7(units_v);
        end
    end

    assign pending_tens_LED  = tens_q;
    assign pending_units_LED = units_q;
`else
    assign pending_tens_LED  = 7'b0000000;
    assign pending_units_LED = 7'b0000000;
`endif

endmodule
